// File: rtl/fetch_align.sv
// Fetch-side aligner: pulls the instruction at pc out of the isram return line,
// stitching RV32C-misaligned 32-bit instructions across two lines.
module fetch_align #(
  parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
  input  logic        clk,
  input  logic        cpurst_n,
  input  logic        isram_cs_ff,
  input  logic [28:0] isram_adr_ff,
  input  logic [63:0] isram_rdata,
  input  logic [31:0] pc,
  input  logic        flush,
  input  logic        stall,
  output logic [31:0] rv32_instr,
  output logic        isrv16,
  output logic        instr_valid,
  output logic [31:0] fetch_pc,
  output logic        fetch_misalign
);

  typedef enum logic {ST_RUN, ST_SPLIT} state_t;

  state_t      r_state;
  logic        r_buf_v;
  logic [28:0] r_buf_tag;
  logic [63:0] r_buf_data;
  logic [15:0] r_hold_lo;
  logic [31:0] r_hold_pc;

  logic              w_unused_pc0;
  logic [31:0]       w_pc;
  logic [28:0]       w_nxt_tag;
  logic              w_in_hit_cur, w_buf_hit_cur, w_cur_hit;
  logic              w_in_hit_nxt, w_buf_hit_nxt, w_nxt_hit;
  logic [3:0][15:0]  w_cur_h;
  logic [15:0]       w_lo, w_hi_same, w_nxt_lo;
  logic              w_emit, w_go_split;
  logic [31:0]       w_emit_word, w_emit_pc;

  assign w_unused_pc0 = pc[0];
  assign w_pc         = {pc[31:1], 1'b0};

  // The "next line" is relative to the held pc while waiting, else the live pc.
  assign w_nxt_tag = ((r_state == ST_SPLIT) ? r_hold_pc[31:3] : pc[31:3]) + 29'd1;

  assign w_in_hit_cur  = isram_cs_ff && (isram_adr_ff == pc[31:3]);
  assign w_buf_hit_cur = r_buf_v && (r_buf_tag == pc[31:3]);
  assign w_cur_hit     = w_in_hit_cur || w_buf_hit_cur;
  assign w_cur_h       = w_in_hit_cur ? isram_rdata : r_buf_data;
  assign w_lo          = w_cur_h[pc[2:1]];
  assign w_hi_same     = w_cur_h[pc[2:1] + 2'd1];

  assign w_in_hit_nxt  = isram_cs_ff && (isram_adr_ff == w_nxt_tag);
  assign w_buf_hit_nxt = r_buf_v && (r_buf_tag == w_nxt_tag);
  assign w_nxt_hit     = w_in_hit_nxt || w_buf_hit_nxt;
  assign w_nxt_lo      = w_in_hit_nxt ? isram_rdata[15:0] : r_buf_data[15:0];

  always_comb begin
    w_emit      = 1'b0;
    w_go_split  = 1'b0;
    w_emit_word = NOP_INSTR;
    w_emit_pc   = w_pc;
    if (r_state == ST_SPLIT) begin
      w_emit      = w_nxt_hit;
      w_emit_word = {w_nxt_lo, r_hold_lo};
      w_emit_pc   = r_hold_pc;
    end else if (w_cur_hit) begin
      if (w_lo[1:0] != 2'b11) begin
        w_emit      = 1'b1;
        w_emit_word = {16'h0000, w_lo};
      end else if (pc[2:1] != 2'b11) begin
        w_emit      = 1'b1;
        w_emit_word = {w_hi_same, w_lo};
      end else if (w_nxt_hit) begin
        w_emit      = 1'b1;
        w_emit_word = {w_nxt_lo, w_lo};
      end else begin
        w_go_split  = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge cpurst_n) begin
    if (!cpurst_n) begin
      r_state        <= ST_RUN;
      r_buf_v        <= 1'b0;
      r_buf_tag      <= '0;
      r_buf_data     <= '0;
      r_hold_lo      <= '0;
      r_hold_pc      <= '0;
      rv32_instr     <= NOP_INSTR;
      isrv16         <= 1'b0;
      instr_valid    <= 1'b0;
      fetch_pc       <= '0;
      fetch_misalign <= 1'b0;
    end else begin
      // Line buffer tracks every returned line regardless of stall/flush.
      if (isram_cs_ff) begin
        r_buf_v    <= 1'b1;
        r_buf_tag  <= isram_adr_ff;
        r_buf_data <= isram_rdata;
      end
      if (flush) begin
        r_state        <= ST_RUN;
        rv32_instr     <= NOP_INSTR;
        isrv16         <= 1'b0;
        instr_valid    <= 1'b0;
        fetch_misalign <= 1'b0;
      end else if (!stall) begin
        if (w_emit) begin
          r_state        <= ST_RUN;
          rv32_instr     <= w_emit_word;
          isrv16         <= (w_emit_word[1:0] != 2'b11);
          fetch_pc       <= w_emit_pc;
          instr_valid    <= 1'b1;
          fetch_misalign <= 1'b0;
        end else if (w_go_split) begin
          r_state        <= ST_SPLIT;
          r_hold_lo      <= w_lo;
          r_hold_pc      <= w_pc;
          instr_valid    <= 1'b0;
          fetch_misalign <= 1'b1;
        end else begin
          instr_valid <= 1'b0;
          if (r_state == ST_RUN) fetch_misalign <= 1'b0;
        end
      end
    end
  end

endmodule

// File: tb/tb_fetch_align.sv
// Directed bench for fetch_align: halfword-level reference model compared every
// cycle, plus literal expectations for the key scenarios.
module tb_fetch_align;

  logic        clk = 1'b0;
  logic        cpurst_n = 1'b0;
  logic        isram_cs_ff = 1'b0;
  logic [28:0] isram_adr_ff = '0;
  logic [63:0] isram_rdata = '0;
  logic [31:0] pc = '0;
  logic        flush = 1'b0;
  logic        stall = 1'b0;
  logic [31:0] rv32_instr;
  logic        isrv16;
  logic        instr_valid;
  logic [31:0] fetch_pc;
  logic        fetch_misalign;

  int total = 0;
  int bad   = 0;
  logic chk_en = 1'b0;

  fetch_align #(.NOP_INSTR(32'h0000_0013)) dut (
    .clk(clk), .cpurst_n(cpurst_n), .isram_cs_ff(isram_cs_ff),
    .isram_adr_ff(isram_adr_ff), .isram_rdata(isram_rdata), .pc(pc),
    .flush(flush), .stall(stall), .rv32_instr(rv32_instr), .isrv16(isrv16),
    .instr_valid(instr_valid), .fetch_pc(fetch_pc), .fetch_misalign(fetch_misalign)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: memory seen as halfwords reachable from IN (preferred) or the buffer.
  logic        m_bv;
  logic [28:0] m_btag;
  logic [63:0] m_bdata;
  logic        m_split;
  logic [15:0] m_hlo;
  logic [31:0] m_hpc;
  logic [31:0] e_instr, e_pc;
  logic        e_16, e_valid, e_mis;

  function automatic logic [16:0] half_at(input logic [31:0] a);
    if (isram_cs_ff && isram_adr_ff == a[31:3]) return {1'b1, isram_rdata[a[2:1]*16 +: 16]};
    if (m_bv && m_btag == a[31:3]) return {1'b1, m_bdata[a[2:1]*16 +: 16]};
    return 17'h0;
  endfunction

  always @(posedge clk or negedge cpurst_n) begin
    logic [16:0] h0, h1;
    logic [31:0] pa;
    if (!cpurst_n) begin
      m_bv <= 0; m_btag <= '0; m_bdata <= '0; m_split <= 0; m_hlo <= '0; m_hpc <= '0;
      e_instr <= 32'h13; e_pc <= '0; e_16 <= 0; e_valid <= 0; e_mis <= 0;
    end else begin
      pa = {pc[31:1], 1'b0};
      if (flush) begin
        e_valid <= 0; e_mis <= 0; e_instr <= 32'h13; e_16 <= 0; m_split <= 0;
      end else if (!stall) begin
        if (m_split) begin
          h1 = half_at(m_hpc + 32'd2);
          if (h1[16]) begin
            e_instr <= {h1[15:0], m_hlo}; e_16 <= 0; e_pc <= m_hpc;
            e_valid <= 1; e_mis <= 0; m_split <= 0;
          end else e_valid <= 0;
        end else begin
          h0 = half_at(pa);
          h1 = half_at(pa + 32'd2);
          if (!h0[16]) begin
            e_valid <= 0; e_mis <= 0;
          end else if (h0[1:0] != 2'b11) begin
            e_instr <= {16'h0, h0[15:0]}; e_16 <= 1; e_pc <= pa; e_valid <= 1; e_mis <= 0;
          end else if (h1[16]) begin
            e_instr <= {h1[15:0], h0[15:0]}; e_16 <= 0; e_pc <= pa; e_valid <= 1; e_mis <= 0;
          end else begin
            m_hlo <= h0[15:0]; m_hpc <= pa; m_split <= 1; e_valid <= 0; e_mis <= 1;
          end
        end
      end
      if (isram_cs_ff) begin
        m_bv <= 1; m_btag <= isram_adr_ff; m_bdata <= isram_rdata;
      end
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      chk("m.valid", {31'h0, instr_valid}, {31'h0, e_valid});
      chk("m.misalign", {31'h0, fetch_misalign}, {31'h0, e_mis});
      chk("m.isrv16", {31'h0, isrv16}, {31'h0, e_16});
      chk("m.instr", rv32_instr, e_instr);
      chk("m.fetch_pc", fetch_pc, e_pc);
    end
  end

  task automatic cyc(input logic cs, input logic [28:0] adr, input logic [63:0] d,
                     input logic [31:0] p, input logic fl, input logic st);
    isram_cs_ff = cs; isram_adr_ff = adr; isram_rdata = d; pc = p; flush = fl; stall = st;
    @(negedge clk);
  endtask

  initial begin
    repeat (2) @(negedge clk);
    chk("rst.instr", rv32_instr, 32'h13);
    chk("rst.valid", {31'h0, instr_valid}, 32'h0);
    chk("rst.fetch_pc", fetch_pc, 32'h0);
    cpurst_n = 1'b1;
    chk_en = 1'b1;

    // aligned 32-bit
    cyc(1, 29'h20, 64'h0000_0000_0062_8293, 32'h100, 0, 0);
    chk("t1.valid", {31'h0, instr_valid}, 32'h1);
    chk("t1.instr", rv32_instr, 32'h0062_8293);
    chk("t1.isrv16", {31'h0, isrv16}, 32'h0);
    chk("t1.pc", fetch_pc, 32'h100);

    // 16-bit at offset, then buffer hit
    cyc(1, 29'h20, 64'h1111_8082_4505_0001, 32'h102, 0, 0);
    chk("t2.instr", {16'h0, rv32_instr[15:0]}, 32'h4505);
    chk("t2.isrv16", {31'h0, isrv16}, 32'h1);
    cyc(0, 29'h0, 64'h0, 32'h104, 0, 0);
    chk("t2.buf_instr", {16'h0, rv32_instr[15:0]}, 32'h8082);
    chk("t2.buf_pc", fetch_pc, 32'h104);

    // split across lines
    cyc(1, 29'h20, 64'h0293_0000_0000_0000, 32'h106, 0, 0);
    chk("t3.misalign", {31'h0, fetch_misalign}, 32'h1);
    chk("t3.valid0", {31'h0, instr_valid}, 32'h0);
    cyc(1, 29'h21, 64'h0000_0000_0000_0062, 32'h300, 0, 0);
    chk("t3.instr", rv32_instr, 32'h0062_0293);
    chk("t3.pc", fetch_pc, 32'h106);
    chk("t3.misalign0", {31'h0, fetch_misalign}, 32'h0);

    // split with BUF + IN both present
    cyc(1, 29'h20, 64'h0293_0000_0000_0000, 32'h400, 0, 0);
    chk("t4.nohit", {31'h0, instr_valid}, 32'h0);
    cyc(1, 29'h21, 64'h0000_0000_0000_0062, 32'h106, 0, 0);
    chk("t4.instr", rv32_instr, 32'h0062_0293);
    chk("t4.misalign", {31'h0, fetch_misalign}, 32'h0);

    // flush during SPLIT
    cyc(1, 29'h3f, 64'h0293_0000_0000_0000, 32'h1fe, 0, 0);
    chk("t5.misalign", {31'h0, fetch_misalign}, 32'h1);
    cyc(0, 29'h0, 64'h0, 32'h1fe, 1, 0);
    chk("t5.flush_valid", {31'h0, instr_valid}, 32'h0);
    chk("t5.flush_instr", rv32_instr, 32'h13);
    cyc(1, 29'h40, 64'h0000_0000_00a0_0513, 32'h200, 0, 0);
    chk("t5.instr", rv32_instr, 32'h00a0_0513);
    chk("t5.pc", fetch_pc, 32'h200);

    // stall with lines arriving
    cyc(1, 29'h50, 64'hFFFF_FFFF_0000_0000, 32'h284, 0, 1);
    chk("t6.stall1", rv32_instr, 32'h00a0_0513);
    cyc(1, 29'h50, 64'h1234_5677_0000_0000, 32'h284, 0, 1);
    chk("t6.stall2", rv32_instr, 32'h00a0_0513);
    cyc(1, 29'h50, 64'h0010_0093_1111_2222, 32'h284, 0, 1);
    chk("t6.stall3", fetch_pc, 32'h200);
    cyc(0, 29'h0, 64'h0, 32'h284, 0, 0);
    chk("t6.release", rv32_instr, 32'h0010_0093);
    chk("t6.pc", fetch_pc, 32'h284);

    // address wrap on the second line
    cyc(1, 29'h1FFF_FFFF, 64'h0293_0000_0000_0000, 32'hFFFF_FFFE, 0, 0);
    chk("wrap.misalign", {31'h0, fetch_misalign}, 32'h1);
    cyc(1, 29'h0, 64'h0000_0000_0000_0062, 32'h0, 0, 0);
    chk("wrap.instr", rv32_instr, 32'h0062_0293);
    chk("wrap.pc", fetch_pc, 32'hFFFF_FFFE);

    // reset mid-SPLIT
    cyc(1, 29'h60, 64'h0293_0000_0000_0000, 32'h306, 0, 0);
    chk("t7.misalign", {31'h0, fetch_misalign}, 32'h1);
    #2 cpurst_n = 1'b0;
    #1;
    chk("t7.instr", rv32_instr, 32'h13);
    chk("t7.valid", {31'h0, instr_valid}, 32'h0);
    chk("t7.misalign0", {31'h0, fetch_misalign}, 32'h0);
    chk("t7.pc", fetch_pc, 32'h0);
    @(negedge clk);
    cpurst_n = 1'b1;
    cyc(1, 29'h61, 64'h0000_0000_0000_4501, 32'h308, 0, 0);
    chk("t7.after", rv32_instr, 32'h0000_4501);

    chk_en = 1'b0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/fetch_align.md
Name: fetch_align

Overview:
- Consumer end of the instruction-SRAM fetch interface. Takes the 64-bit lines returned by isram, one cycle after the address generator asserts isram_cs, and extracts the instruction at the current pc.
- Handles RV32C halfword alignment. A 32-bit instruction at pc[2:1]==2'b11 spans two lines and is stitched from both.
- Holds the last returned line in a one-entry line buffer.
- Feeds the decode stage through registered outputs.

Parameters:
NOP_INSTR, 32'h0000_0013, instruction value driven on rv32_instr during reset and flush.

Ports:
clk  in  1  core clock, rising edge
cpurst_n  in  1  asynchronous active-low reset
isram_cs_ff  in  1  isram_rdata/isram_adr_ff carry a valid returned line this cycle
isram_adr_ff  in  29  line address [31:3] of the returned line
isram_rdata  in  64  returned line; halfword k is bits [16k+15:16k]
pc  in  32  current fetch pc; pc[0] is ignored
flush  in  1  redirect (jump/branch_predict_err); discards partial and output state
stall  in  1  decode back-pressure; holds outputs and state
rv32_instr  out  32  extracted instruction; upper 16 bits are don't-care when isrv16=1
isrv16  out  1  rv32_instr[1:0]!=2'b11
instr_valid  out  1  rv32_instr/fetch_pc are valid
fetch_pc  out  32  pc of rv32_instr
fetch_misalign  out  1  waiting for the second line of a split instruction

Behaviour:
- Reset (async, cpurst_n=0):
  - rv32_instr=NOP_INSTR; isrv16, instr_valid, fetch_misalign=0; fetch_pc=0.
  - Line buffer invalid; state=RUN; hold registers cleared.
- Sources:
  - IN: the returned line, valid when isram_cs_ff=1.
  - BUF: the line buffer (buf_v, buf_tag[31:3], buf_data).
  - Each cycle with isram_cs_ff=1, BUF<=IN. This happens even under stall or flush.
  - A source "hits" address A when it is valid and its tag==A[31:3]. IN has priority over BUF when both hit.
- Extraction in RUN:
  - cur = hitting line for pc; lo = halfword pc[2:1] of cur.
  - lo[1:0]!=2'b11 -> 16-bit; emit {16'h0, lo}.
  - 32-bit, pc[2:1]!=3 -> emit {halfword pc[2:1]+1, lo} from the same line.
  - 32-bit, pc[2:1]==3 -> nxt = source hitting pc[31:3]+1 (29-bit wrap allowed).
    - nxt hit: emit {nxt[15:0], lo}.
    - nxt miss: hold_lo<=lo, hold_pc<=pc; go SPLIT; instr_valid<=0; fetch_misalign<=1.
  - No hit for pc -> instr_valid<=0, fetch_misalign<=0.
- SPLIT:
  - When a source hits hold_pc[31:3]+1: emit {that[15:0], hold_lo} with fetch_pc=hold_pc; go RUN; fetch_misalign<=0.
  - Otherwise stay in SPLIT, instr_valid=0.
  - While in SPLIT, the pc input is ignored.
- Emit means, at the next clock edge: rv32_instr, isrv16 and fetch_pc are loaded, and instr_valid<=1.
  - Latency: one cycle from the line on IN (or pc change on a BUF hit) to instr_valid.
  - Emitted rv32_instr equals the instruction word; isrv16 is derived from its bits [1:0].
- stall=1:
  - All output registers, state, hold_lo and hold_pc hold.
  - Only the line buffer updates.
- flush=1 (priority over stall):
  - Next edge: instr_valid<=0, fetch_misalign<=0, rv32_instr<=NOP_INSTR, state<=RUN.
  - The line buffer is kept, since its data is still correct.
  - A line arriving in the same cycle is still captured into BUF.
- Reset asserted mid-SPLIT: the partial instruction is dropped; outputs return to reset values immediately.

Test Plan:
1. Aligned 32-bit: pc=0x100, IN tag 0x20, rdata=64'h0000_0000_0062_8293 -> next cycle instr_valid=1, rv32_instr=32'h0062_8293, isrv16=0, fetch_pc=0x100.
2. 16-bit at offset: pc=0x102, rdata halfword1=16'h4505 -> rv32_instr[15:0]=16'h4505, isrv16=1. Then pc=0x104, no new line; BUF hit -> emits halfword2 next cycle.
3. Split instruction:
   - pc=0x106, line 0x100 with halfword3=16'h0293 -> fetch_misalign=1, instr_valid=0.
   - Line 0x108 with halfword0=16'h0062 arrives -> rv32_instr=32'h0062_0293, fetch_pc=0x106, fetch_misalign=0.
4. Split with both lines available (BUF=0x100, IN=0x108), pc=0x106 -> emitted in one cycle, no SPLIT entry.
5. Flush during SPLIT, then pc=0x200 with its line -> SPLIT abandoned; instr_valid=0 for one cycle; 0x200 instruction emitted, not a stitched value.
6. stall=1 for 3 cycles after an emit, with new lines arriving -> outputs unchanged. After release, emission uses the latest BUF. Then cpurst_n low mid-SPLIT -> outputs immediately at reset values, rv32_instr=32'h0000_0013.
